sevenseg_capture: RTL

Receive-side monitor for the multiplexed 4-digit seven-segment bus. It samples `seg`/`an` as driven by the display multiplexer, or by an external board. It waits for each digit's dwell to settle, decodes the segment pattern back to a BCD nibble, and publishes the reconstructed 16-bit `{d3,d2,d1,d0}` value once all four digits of a frame have been captured. It sits beside the display driver in the parking-FSM top level for self-check, or on input pins when reading a foreign display.

---
 rtl/sevenseg_capture.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: receive-side monitor for a multiplexed 4-digit
// seven-segment bus. It synchronises seg/an, waits for each digit's dwell
// to settle, decodes the segment pattern back to a BCD nibble and publishes
// the reconstructed {d3,d2,d1,d0} value once all four digits are captured.
//
// Optional build macro: SEVENSEG_CAPTURE_ERR_EN
//   defined   : unrecognised patterns set the sticky decode_err flag and the
//               frame containing them is dropped at mask completion.
//   undefined : decode_err is tied low and nibble E is published normally.
//
// Output handshake: value_valid is a single-cycle strobe with no
// backpressure; value changes only in a strobe cycle and holds until the
// next one. frame_cnt changes in the same cycle as the strobe.

module sevenseg_capture #(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BIT_REVERSE    = 1,
    parameter int SETTLE_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [7:0]  frame_cnt,
    output logic        decode_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Raw levels meaning "nothing lit", so the synchronisers come out of
    // reset looking like a dark display rather than all segments/anodes on.
    localparam logic [6:0]  SEG_IDLE_RAW  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_IDLE_RAW   = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;
    localparam logic [15:0] SETTLE_TARGET = 16'(SETTLE_CYCLES);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [6:0] seg_s1_q, seg_s2_q;
    logic [3:0] an_s1_q, an_s2_q;

    // Two-flop synchronisers for the asynchronous segment and anode lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= SEG_IDLE_RAW;
            seg_s2_q <= SEG_IDLE_RAW;
            an_s1_q  <= AN_IDLE_RAW;
            an_s2_q  <= AN_IDLE_RAW;
        end else begin
            seg_s1_q <= seg;
            seg_s2_q <= seg_s1_q;
            an_s1_q  <= an;
            an_s2_q  <= an_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Polarity and bit-order normalisation
    // ------------------------------------------------------------------
    logic [6:0] seg_pol;
    logic [6:0] seg_canon;   // bit 6 = a ... bit 0 = g
    logic [3:0] an_act;      // 1 = anode active

    // Fold the configured polarities away and put segments in {a..g} order.
    always_comb begin
        seg_pol   = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_q : seg_s2_q;
        an_act    = (AN_ACTIVE_LOW  != 0) ? ~an_s2_q  : an_s2_q;
        seg_canon = 7'b0;
        for (int i = 0; i < 7; i++) begin
            seg_canon[i] = (BIT_REVERSE != 0) ? seg_pol[6 - i] : seg_pol[i];
        end
    end

    // ------------------------------------------------------------------
    // Anode decode: exactly one active anode is a valid digit select
    // ------------------------------------------------------------------
    logic       an_valid;
    logic [1:0] an_idx;

    // One-hot check and index extraction for the active anode.
    always_comb begin
        an_valid = 1'b0;
        an_idx   = 2'd0;
        case (an_act)
            4'b0001: begin an_valid = 1'b1; an_idx = 2'd0; end
            4'b0010: begin an_valid = 1'b1; an_idx = 2'd1; end
            4'b0100: begin an_valid = 1'b1; an_idx = 2'd2; end
            4'b1000: begin an_valid = 1'b1; an_idx = 2'd3; end
            default: begin an_valid = 1'b0; an_idx = 2'd0; end
        endcase
    end

    // ------------------------------------------------------------------
    // Reverse segment LUT
    // ------------------------------------------------------------------
    logic [3:0] nib;
    logic       code_err;

    // Map a canonical segment pattern back to its nibble; unknown -> E.
    always_comb begin
        code_err = 1'b0;
        nib      = 4'hE;
        case (seg_canon)
            7'b1111110: nib = 4'h0;
            7'b0110000: nib = 4'h1;
            7'b1101101: nib = 4'h2;
            7'b1111001: nib = 4'h3;
            7'b0110011: nib = 4'h4;
            7'b1011011: nib = 4'h5;
            7'b1011111: nib = 4'h6;
            7'b1110000: nib = 4'h7;
            7'b1111111: nib = 4'h8;
            7'b1111011: nib = 4'h9;
            7'b0000000: nib = 4'hF;
            default: begin
                nib      = 4'hE;
                code_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Dwell tracking FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  an_prev_q;
    logic [6:0]  seg_prev_q;
    logic        stable;
    logic        an_changed;
    logic        capture;

    assign an_changed = (an_act != an_prev_q);
    assign stable     = !an_changed && (seg_canon == seg_prev_q);
    assign dbg_state  = state_q;

    // State, settle counter and previous-cycle view of the normalised bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            an_prev_q  <= 4'd0;
            seg_prev_q <= 7'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            an_prev_q  <= an_act;
            seg_prev_q <= seg_canon;
        end
    end

    // Next-state logic. Stability includes the anode, so an anode change on
    // the cycle the count would complete reloads instead of capturing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (an_valid) begin
                    state_d = S_SETTLE;
                    cnt_d   = 16'd1;
                end
            end
            S_SETTLE: begin
                if (!an_valid) begin
                    state_d = S_IDLE;
                end else if (!stable) begin
                    cnt_d = 16'd1;
                end else if (cnt_q == SETTLE_TARGET - 16'd1) begin
                    cnt_d   = SETTLE_TARGET;
                    capture = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                // One capture per dwell: only an anode change leaves HOLD.
                if (an_changed) begin
                    if (an_valid) begin
                        state_d = S_SETTLE;
                        cnt_d   = 16'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit registers, capture mask and frame publish
    // ------------------------------------------------------------------
    logic [15:0] digits_q, digits_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  cap_bit;
    logic        publish;
    logic        pub_ok;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic [7:0]  fcnt_q, fcnt_d;

    assign cap_bit = capture ? (4'b0001 << an_idx) : 4'b0000;
    assign publish = (mask_q == 4'hF);

    // Digit overwrite, mask accumulation and publish of a completed frame.
    // A capture landing in the publish cycle starts the next frame's mask.
    always_comb begin
        digits_d = digits_q;
        for (int i = 0; i < 4; i++) begin
            if (cap_bit[i]) begin
                digits_d[4*i +: 4] = nib;
            end
        end
        mask_d  = publish ? cap_bit : (mask_q | cap_bit);
        value_d = pub_ok ? digits_q : value_q;
        valid_d = pub_ok;
        fcnt_d  = pub_ok ? fcnt_q + 8'd1 : fcnt_q;
    end

    // Frame datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= 16'hFFFF;
            mask_q   <= 4'd0;
            value_q  <= 16'hFFFF;
            valid_q  <= 1'b0;
            fcnt_q   <= 8'd0;
        end else begin
            digits_q <= digits_d;
            mask_q   <= mask_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            fcnt_q   <= fcnt_d;
        end
    end

`ifdef SEVENSEG_CAPTURE_ERR_EN
    logic err_q, err_d;
    logic bad_q, bad_d;
    logic cap_err;

    assign cap_err = capture && code_err;

    // Sticky error flag and per-frame bad marker, cleared at mask completion.
    always_comb begin
        err_d  = err_q | cap_err;
        bad_d  = publish ? cap_err : (bad_q | cap_err);
        pub_ok = publish && !bad_q;
    end

    // Error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            err_q <= err_d;
            bad_q <= bad_d;
        end
    end

    assign decode_err = err_q;
`else
    logic code_err_unused;

    assign code_err_unused = code_err;
    assign pub_ok          = publish;
    assign decode_err      = 1'b0;
`endif

    assign value       = value_q;
    assign value_valid = valid_q;
    assign frame_cnt   = fcnt_q;

endmodule
